// File: rtl/lvds_fa_pkg.sv
// Shared types and constants for the LVDS per-lane frame aligner and its
// window-select helper.
package lvds_fa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } fa_state_t;

    localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'hE1;

    // Debug status word layout, MSB first
    typedef struct packed {
        logic       fa_fail;
        logic       fa_lock;
        logic [2:0] state;
        logic [2:0] offset;
    } fa_debug_t;

    // Counter width for a count limit, never narrower than one bit
    function automatic int cnt_width(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/lvds_frame_aligner_if.sv
// Lane-side bus of the frame aligner: raw words and start request in,
// aligned words and status out.
interface lvds_frame_aligner_if;

    logic       start;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       fa_lock;
    logic       fa_fail;
    logic [2:0] offset;
    logic [7:0] fa_out;

    modport master (
        output start,
        output data_in,
        input  data_out,
        input  fa_lock,
        input  fa_fail,
        input  offset,
        input  fa_out
    );

    modport slave (
        input  start,
        input  data_in,
        output data_out,
        output fa_lock,
        output fa_fail,
        output offset,
        output fa_out
    );

endinterface

// File: rtl/lvds_window_select.sv
// Registered 8-bit window taken from two consecutive raw words at a bit offset.
// Shared with the TX-side skew injector, so it knows nothing about alignment.
module lvds_window_select (
    input  logic       rx_slowclk,
    input  logic       rstn,
    input  logic [7:0] data_in,
    input  logic [7:0] prev_q,
    input  logic [2:0] offset,
    output logic [7:0] window_q
);

    logic [15:0] concat;

    // Newest word sits in the upper byte, so offset k rotates a repeating byte right by k
    assign concat = {data_in, prev_q};

    always_ff @(posedge rx_slowclk) begin
        if (!rstn) begin
            window_q <= '0;
        end else begin
            window_q <= concat[offset +: 8];
        end
    end

endmodule

// File: rtl/lvds_frame_aligner.sv
// Per-lane LVDS byte aligner: slides an 8-bit window until the training byte
// repeats, then freezes it. Optional debug status word: LVDS_FRAME_ALIGNER_DEBUG_EN.
module lvds_frame_aligner
    import lvds_fa_pkg::*;
#(
    parameter logic [7:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         MATCH_COUNT   = 16
) (
    input logic                 rx_slowclk,
    input logic                 rstn,
    lvds_frame_aligner_if.slave bus
);

    localparam int SW = cnt_width(SETTLE_CYCLES);
    localparam int MW = cnt_width(MATCH_COUNT);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);

    fa_state_t     state_q,    state_d;
    logic [2:0]    offset_q,   offset_d;
    logic [SW-1:0] settle_q,   settle_d;
    logic [MW-1:0] match_q,    match_d;
    logic          fa_lock_q,  fa_lock_d;
    logic          fa_fail_q,  fa_fail_d;
    logic          start_q;
    logic          start_edge;
    logic [7:0]    prev_q;
    logic [7:0]    window_q;

    assign start_edge = bus.start & ~start_q;

    lvds_window_select u_window (
        .rx_slowclk (rx_slowclk),
        .rstn       (rstn),
        .data_in    (bus.data_in),
        .prev_q     (prev_q),
        .offset     (offset_q),
        .window_q   (window_q)
    );

    always_ff @(posedge rx_slowclk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            offset_q  <= '0;
            settle_q  <= '0;
            match_q   <= '0;
            fa_lock_q <= 1'b0;
            fa_fail_q <= 1'b0;
            start_q   <= 1'b0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            settle_q  <= settle_d;
            match_q   <= match_d;
            fa_lock_q <= fa_lock_d;
            fa_fail_q <= fa_fail_d;
            start_q   <= bus.start;
            prev_q    <= bus.data_in;
        end
    end

    // A start edge overrides whatever the search was doing, including a held lock or fail
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        settle_d = settle_q;
        match_d  = match_q;

        if (start_edge) begin
            state_d  = ST_SETTLE;
            offset_d = '0;
            settle_d = '0;
            match_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = ST_CHECK;
                        match_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (window_q == TRAIN_PATTERN) begin
                        if (match_q == MATCH_LAST) begin
                            state_d = ST_LOCKED;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else if (offset_q == 3'd7) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d  = ST_SETTLE;
                        offset_d = offset_q + 3'd1;
                        settle_d = '0;
                    end
                end
                ST_LOCKED: begin
                end
                ST_FAIL: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status follows the state one cycle late, but drops together with a restart
        fa_lock_d = ~start_edge & (state_q == ST_LOCKED);
        fa_fail_d = ~start_edge & (state_q == ST_FAIL);
    end

    assign bus.data_out = window_q;
    assign bus.fa_lock  = fa_lock_q;
    assign bus.fa_fail  = fa_fail_q;
    assign bus.offset   = offset_q;

`ifdef LVDS_FRAME_ALIGNER_DEBUG_EN
    fa_debug_t dbg_q;

    always_ff @(posedge rx_slowclk) begin
        if (!rstn) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= '{fa_fail: fa_fail_q, fa_lock: fa_lock_q, state: state_q, offset: offset_q};
        end
    end

    assign bus.fa_out = dbg_q;
`else
    assign bus.fa_out = 8'h00;
`endif

endmodule
